// File: rtl/sp_bram_bytewe_multimode_if.sv
// Access/clear bus for the byte-lane single-port RAM.
// Latency: n/a (signal bundle only).
// Backpressure: none; the master must respect clr_busy (accesses are ignored while it is high).
interface sp_bram_bytewe_multimode_if #(
  parameter int ADDR_WIDTH = 9,
  parameter int W          = 16,
  parameter int NB_COL     = 2
);
  logic                  en;
  logic [NB_COL-1:0]     we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [W-1:0]          di;
  logic [W-1:0]          dout;
  logic                  do_valid;
  logic                  clr_start;
  logic                  clr_busy;
  logic                  clr_done;

  modport master (
    output en, we, addr, di, clr_start,
    input  dout, do_valid, clr_busy, clr_done
  );

  modport slave (
    input  en, we, addr, di, clr_start,
    output dout, do_valid, clr_busy, clr_done
  );
endinterface

// File: rtl/sp_bram_bytewe_multimode.sv
// Single-port byte-lane RAM with selectable read-during-write mode and a fill/clear engine.
// Latency: read data and do_valid 1 cycle after acceptance (2 with OUT_REG=1); clear takes DEPTH cycles.
// Backpressure: none on data; accesses presented while clr_busy is high are dropped silently.
module sp_bram_bytewe_multimode #(
  parameter int DEPTH      = 512,
  parameter int ADDR_WIDTH = 9,
  parameter int COL_WIDTH  = 8,
  parameter int NB_COL     = 2,
  parameter int WRITE_MODE = 0,
  parameter int OUT_REG    = 0,
  parameter logic [NB_COL*COL_WIDTH-1:0] CLEAR_VAL = '0
) (
  input  logic clk_i,
  input  logic rst_i,
  sp_bram_bytewe_multimode_if.slave bus
);
  localparam int W = NB_COL * COL_WIDTH;
  // One extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
  localparam logic [ADDR_WIDTH:0]   DEPTH_X   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CLEAR, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
  logic [W-1:0]          mem_q [DEPTH];

  logic                  acc;
  logic                  in_range;
  logic [W-1:0]          old_word;
  logic [W-1:0]          new_word;
  logic [W-1:0]          rd_dat;
  logic                  rd_vld;
  logic [W-1:0]          s1_dat_q;
  logic                  s1_vld_q;

  assign acc      = bus.en && (state_q != ST_CLEAR);
  assign in_range = {1'b0, bus.addr} < DEPTH_X;

  // Clear FSM state register and sweep counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  // Clear FSM next state: sweep 0..DEPTH-1 once, then a single DONE cycle
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.clr_start) begin
          state_d   = ST_CLEAR;
          clr_cnt_d = '0;
        end
      end
      ST_CLEAR: begin
        if (clr_cnt_q == LAST_ADDR) state_d = ST_DONE;
        else                        clr_cnt_d = clr_cnt_q + 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear FSM outputs
  always_comb begin
    bus.clr_busy = (state_q == ST_CLEAR);
    bus.clr_done = (state_q == ST_DONE);
  end

  // Read path: stored word, merged word, and the mode-dependent response
  always_comb begin
    old_word = in_range ? mem_q[bus.addr] : '0;
    new_word = old_word;
    for (int i = 0; i < NB_COL; i++) begin
      if (bus.we[i]) new_word[i*COL_WIDTH +: COL_WIDTH] = bus.di[i*COL_WIDTH +: COL_WIDTH];
    end
    rd_dat = old_word;
    rd_vld = acc;
    if (WRITE_MODE == 0) begin
      // Out-of-range reads must return zero even when lanes are being written.
      rd_dat = in_range ? new_word : '0;
    end else if (WRITE_MODE == 2 && (|bus.we)) begin
      rd_vld = 1'b0;
    end
  end

  // RAM array: no reset so it maps onto block RAM; clear sweep owns the port while busy
  always_ff @(posedge clk_i) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_cnt_q] <= CLEAR_VAL;
    end else if (acc && in_range) begin
      for (int i = 0; i < NB_COL; i++) begin
        if (bus.we[i]) mem_q[bus.addr][i*COL_WIDTH +: COL_WIDTH] <= bus.di[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  // First output stage: data holds between accepted reads
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_dat_q <= '0;
      s1_vld_q <= 1'b0;
    end else begin
      s1_vld_q <= rd_vld;
      if (rd_vld) s1_dat_q <= rd_dat;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      logic [W-1:0] s2_dat_q;
      logic         s2_vld_q;

      // Optional second stage: forwards every strobe one cycle later, holds otherwise
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          s2_dat_q <= '0;
          s2_vld_q <= 1'b0;
        end else begin
          s2_vld_q <= s1_vld_q;
          if (s1_vld_q) s2_dat_q <= s1_dat_q;
        end
      end

      assign bus.dout     = s2_dat_q;
      assign bus.do_valid = s2_vld_q;
    end else begin : g_noreg
      assign bus.dout     = s1_dat_q;
      assign bus.do_valid = s1_vld_q;
    end
  endgenerate
endmodule
